rtype_instr_encoder: RTL and testbench

- Issue-side counterpart of the ALU control decoder. Accepts ALU operation requests as a 3-bit ALU select plus register fields, and encodes each into a 32-bit R-type instruction word whose function code decodes back to the same select.
- Buffers encoded words in a small FIFO and presents them to the instruction-fetch/test-driver side over a valid/ready handshake.
- Rejects the unencodable select and counts the rejections.

---
 rtl/rtype_instr_encoder_if.sv | 46 ++++
 rtl/rtype_instr_encoder.sv | 138 +++++++++++++
 tb/tb_rtype_instr_encoder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtype_instr_encoder_if.sv
// rtype_instr_encoder_if
// Request/response bus of the R-type instruction encoder.
//   Request side : in_valid/in_ready handshake carrying the ALU select
//                  (in_sel) and register fields (in_rs, in_rt, in_rd, in_shamt).
//   Response side: out_valid/out_ready handshake carrying the encoded
//                  32-bit instruction word (out_instr).
// The master modport is the requester/consumer (test driver, fetch side).
// The slave modport is the encoder itself.
interface rtype_instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_sel;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;

   modport master (
      output in_valid,
      output in_sel,
      output in_rs,
      output in_rt,
      output in_rd,
      output in_shamt,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_instr
   );

   modport slave (
      input  in_valid,
      input  in_sel,
      input  in_rs,
      input  in_rt,
      input  in_rd,
      input  in_shamt,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_instr
   );
endinterface

// File: rtl/rtype_instr_encoder.sv
// rtype_instr_encoder
// Encodes ALU operation requests (3-bit ALU select + register fields) into
// 32-bit R-type instruction words whose function code decodes back to the
// same select, queues them in a DEPTH-entry FIFO and presents them over a
// valid/ready handshake. Select 3 has no function code: such requests are
// consumed but not queued, and raise a sticky flag plus a saturating counter.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          request/response handshakes (slave modport)
//   count        FIFO occupancy, 0..DEPTH
//   err_illegal  sticky flag, set when an illegal select is accepted
//   err_clr      clears err_illegal (an illegal accept on the same edge wins)
//   illegal_cnt  saturating count of accepted illegal requests
module rtype_instr_encoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   rtype_instr_encoder_if.slave       bus,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err_illegal,
   input  logic                       err_clr,
   output logic [CNT_W-1:0]           illegal_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

   logic             sel_legal;
   logic             accept;
   logic             push;
   logic             pop;
   logic             accept_illegal;
   logic [4:0]       shamt_eff;
   logic [31:0]      word;

   // Function code for each ALU select; select 3 never reaches the FIFO,
   // so its value here is irrelevant.
   function automatic logic [5:0] funct_of(input logic [2:0] sel);
      logic [5:0] f;
      case (sel)
         3'd0:    f = 6'b100100;
         3'd1:    f = 6'b100101;
         3'd2:    f = 6'b100000;
         3'd4:    f = 6'b100010;
         3'd5:    f = 6'b000010;
         3'd6:    f = 6'b000000;
         3'd7:    f = 6'b100111;
         default: f = 6'b000000;
      endcase
      return f;
   endfunction

   // in_ready is derived only from registered occupancy, so there is no
   // combinational path from out_ready; a pop while full frees the slot
   // one cycle later.
   assign bus.in_ready  = (count_q < FULL_CNT);
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = (count_q != '0) ? mem_q[rd_ptr_q] : 32'h0;

   assign count       = count_q;
   assign err_illegal = err_q;
   assign illegal_cnt = ill_cnt_q;

   assign sel_legal      = (bus.in_sel != 3'd3);
   assign accept         = bus.in_valid & bus.in_ready;
   assign push           = accept & sel_legal;
   assign accept_illegal = accept & ~sel_legal;
   assign pop            = bus.out_valid & bus.out_ready;

   // Only shift operations (sel 5 and 6) carry a shift amount.
   assign shamt_eff = ((bus.in_sel == 3'd5) || (bus.in_sel == 3'd6)) ? bus.in_shamt : 5'd0;
   assign word      = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, shamt_eff, funct_of(bus.in_sel)};

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      err_d     = err_q;
      ill_cnt_d = ill_cnt_q;

      if (push) begin
         mem_d[wr_ptr_q] = word;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Setting takes priority over clearing on the same edge.
      if (accept_illegal) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end

      if (accept_illegal && (ill_cnt_q != {CNT_W{1'b1}})) begin
         ill_cnt_d = ill_cnt_q + 1'b1;
      end
   end

   // Storage is not cleared by reset: with count at zero the contents are
   // unreachable and out_instr is forced to zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
         ill_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_q     <= err_d;
         ill_cnt_q <= ill_cnt_d;
      end
   end

endmodule

// File: tb/tb_rtype_instr_encoder.sv
// tb_rtype_instr_encoder
// Self-checking bench for rtype_instr_encoder: a table of encode vectors,
// hand-written sequences for full/wrap/illegal/reset corners, and a random
// phase, all compared against a queue-based reference model.
module tb_rtype_instr_encoder;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             err_clr;
   logic [2:0]       count;
   logic             err_illegal;
   logic [CNT_W-1:0] illegal_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mq[$];
   bit          m_err;
   int          m_cnt;

   typedef struct {
      int          sel;
      int          rs;
      int          rt;
      int          rd;
      int          sh;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   rtype_instr_encoder_if bus();

   rtype_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .count       (count),
      .err_illegal (err_illegal),
      .err_clr     (err_clr),
      .illegal_cnt (illegal_cnt)
   );

   function automatic int ref_funct(int sel);
      int tab[8] = '{36, 37, 32, -1, 34, 2, 0, 39};
      return tab[sel];
   endfunction

   // ALU control unit: function code back to select, -1 if none.
   function automatic int alu_decode(int f);
      int r = -1;
      for (int s = 0; s < 8; s++) begin
         if (s != 3 && ref_funct(s) == f) r = s;
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_word(int sel, int rs, int rt, int rd, int sh);
      int s_eff = (sel == 5 || sel == 6) ? sh : 0;
      return 32'(rs * 2097152 + rt * 65536 + rd * 2048 + s_eff * 64 + ref_funct(sel));
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, advance one edge, update the model.
   task automatic applyStimulus(bit v, int sel, int rs, int rt, int rd, int sh,
                                bit ordy, bit clr, bit rstn);
      bit acc;
      bit pop;
      bus.in_valid  = v;
      bus.in_sel    = 3'(sel);
      bus.in_rs     = 5'(rs);
      bus.in_rt     = 5'(rt);
      bus.in_rd     = 5'(rd);
      bus.in_shamt  = 5'(sh);
      bus.out_ready = ordy;
      err_clr       = clr;
      rst_n         = rstn;
      @(posedge clk);
      if (!rstn) begin
         mq.delete();
         m_err = 0;
         m_cnt = 0;
      end else begin
         acc = v && (mq.size() < DEPTH);
         pop = (mq.size() != 0) && ordy;
         if (pop) void'(mq.pop_front());
         if (acc && sel == 3) begin
            m_err = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
         end else begin
            if (clr) m_err = 0;
            if (acc) mq.push_back(ref_word(sel, rs, rt, rd, sh));
         end
      end
      #1;
   endtask

   task automatic idle(bit ordy);
      applyStimulus(0, 0, 0, 0, 0, 0, ordy, 0, 1);
   endtask

   task automatic checkOutput(string tag);
      check({tag, ".count"},     32'(count),          32'(mq.size()));
      check({tag, ".out_valid"}, 32'(bus.out_valid),  32'(mq.size() != 0));
      check({tag, ".out_instr"}, bus.out_instr,       (mq.size() != 0) ? mq[0] : 32'h0);
      check({tag, ".in_ready"},  32'(bus.in_ready),   32'(mq.size() < DEPTH));
      check({tag, ".err"},       32'(err_illegal),    32'(m_err));
      check({tag, ".ill_cnt"},   32'(illegal_cnt),    32'(m_cnt));
   endtask

   initial begin
      vecs[0] = '{2,  1,  2,  3,  7, 32'h00221820};
      vecs[1] = '{6,  0,  5,  4,  2, 32'h00052080};
      vecs[2] = '{0,  0,  0,  0,  0, 32'h00000024};
      vecs[3] = '{1, 31, 31, 31, 31, 32'h03FFF825};
      vecs[4] = '{4,  2,  3,  4,  1, 32'h00432022};
      vecs[5] = '{5,  0,  7,  8,  3, 32'h000740C2};
      vecs[6] = '{7,  4,  5,  6,  9, 32'h00853027};

      mq.delete();
      m_err = 0;
      m_cnt = 0;

      // Reset
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("reset.count",     32'(count),         32'd0);
      check("reset.out_valid", 32'(bus.out_valid), 32'd0);
      check("reset.out_instr", bus.out_instr,      32'h0);
      check("reset.err",       32'(err_illegal),   32'd0);
      check("reset.ill_cnt",   32'(illegal_cnt),   32'd0);

      // First push: shamt zeroed for sel=2
      applyStimulus(1, 2, 1, 2, 3, 7, 0, 0, 1);
      check("first.out_valid", 32'(bus.out_valid), 32'd1);
      check("first.out_instr", bus.out_instr,      32'h00221820);
      check("first.count",     32'(count),         32'd1);
      idle(1);
      checkOutput("first_pop");

      // Table: every legal select, decoded back through the ALU control unit
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1, vecs[i].sel, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, 0, 0, 1);
         checkOutput($sformatf("vec%0d", i));
         check($sformatf("vec%0d.instr", i), bus.out_instr, vecs[i].exp_instr);
         check($sformatf("vec%0d.decode", i), 32'(alu_decode(int'(bus.out_instr[5:0]))), 32'(vecs[i].sel));
         idle(1);
         checkOutput($sformatf("vec%0d_pop", i));
      end

      // Fill to full, blocked 5th request, pop frees a slot next cycle
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, (i == 3) ? 4 : i, i + 1, i + 2, i + 3, i, 0, 0, 1);
      end
      checkOutput("full");
      check("full.count",    32'(count),        32'd4);
      check("full.in_ready", 32'(bus.in_ready), 32'd0);
      applyStimulus(1, 7, 9, 9, 9, 0, 0, 0, 1);
      check("blocked.count", 32'(count), 32'd4);
      checkOutput("blocked");
      applyStimulus(1, 7, 10, 10, 10, 0, 1, 0, 1);
      check("pop_full.count",    32'(count),        32'd3);
      check("pop_full.in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("pop_full");
      for (int i = 0; i < DEPTH; i++) begin
         idle(1);
         checkOutput($sformatf("drain%0d", i));
      end

      // Continuous push+pop across pointer wrap
      applyStimulus(1, 0, 1, 1, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         applyStimulus(1, (i % 2) ? 5 : 1, i, i + 1, i + 2, i + 3, 1, 0, 1);
         checkOutput($sformatf("wrap%0d", i));
         check($sformatf("wrap%0d.count", i), 32'(count), 32'd1);
      end
      idle(1);
      checkOutput("wrap_end");

      // Illegal select, err_clr interactions
      applyStimulus(1, 3, 1, 2, 3, 4, 0, 0, 1);
      check("ill1.count", 32'(count),       32'd0);
      check("ill1.err",   32'(err_illegal), 32'd1);
      check("ill1.cnt",   32'(illegal_cnt), 32'd1);
      applyStimulus(1, 3, 1, 2, 3, 4, 0, 1, 1);
      check("ill2.err", 32'(err_illegal), 32'd1);
      check("ill2.cnt", 32'(illegal_cnt), 32'd2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      check("clr.err", 32'(err_illegal), 32'd0);
      check("clr.cnt", 32'(illegal_cnt), 32'd2);
      checkOutput("clr");

      // Counter saturation
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 1);
      end
      check("sat.cnt", 32'(illegal_cnt), 32'(CNT_MAX));
      checkOutput("sat");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 7),
                       $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 1), $urandom_range(0, 9) == 0, 1);
         checkOutput($sformatf("rnd%0d", i));
      end

      // Reset mid-stream with queued words and error flag set
      for (int i = 0; i < DEPTH; i++) idle(1);
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(1, 7, i, i, i, 0, 0, 0, 1);
      check("prerst.count", 32'(count), 32'd3);
      applyStimulus(1, 2, 5, 5, 5, 0, 1, 0, 0);
      check("midrst.count",     32'(count),         32'd0);
      check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst.out_instr", bus.out_instr,      32'h0);
      check("midrst.err",       32'(err_illegal),   32'd0);
      check("midrst.ill_cnt",   32'(illegal_cnt),   32'd0);
      idle(0);
      checkOutput("postrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
